rf_hazard_scoreboard: RTL and testbench
=======================================

Name: rf_hazard_scoreboard

Overview:
- Issue controller for the register-file/decode stage of the pipelined miniRV core.
- Tracks in-flight destination registers of issued instructions through a DEPTH-slot shift pipeline (slot 0 = EX, slot DEPTH-1 = WB).
- Decides each cycle whether the instruction in decode may issue or must stall.
- Optionally drives operand bypass selects for rD1/rD2 and keeps a stall-cycle counter.

Parameters:
- DEPTH, 3: number of tracked stages after decode (EX..WB); legal range 3-6.
- CNT_W, 32: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1  in  5  inst[19:15] of the decode instruction.
- id_rs2  in  5  inst[24:20] of the decode instruction.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  5  inst[11:7] of the decode instruction.
- id_rf_we  in  1  instruction writes the RF.
- id_rf_wsel  in  2  writeback select: 0 ALU, 1 RAM (load), 2 PC4, 3 EXT.
- flush  in  1  branch/jump redirect; the decode instruction is killed.
- stall  out  1  hold PC and decode register this cycle.
- issue  out  1  decode instruction enters EX at next edge.
- fwd_sel1  out  2  rD1 bypass: 0 RF, 1 EX, 2 MEM, 3 WB.
- fwd_sel2  out  2  rD2 bypass, same encoding as fwd_sel1.
- rf_busy  out  32  bit r set when any valid slot has we=1 and rd=r; bit 0 is always 0.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Slot contents: {v, rd, we, ld}. A slot entry is "writing" when v=1, we=1 and rd!=0. ld=1 when id_rf_wsel==1.
- Every edge: slot[k+1] <= slot[k] for all k; the WB slot retires.
- slot[0] <= {1, id_rd, id_rf_we, ld} when issue=1; otherwise slot[0] <= bubble (v=0).
- Operand match: operand rsN (N=1,2) is checked only when rsN_used=1 and rsN!=0. It matches slot k when slot k is writing and slot[k].rd==rsN.
- Youngest match is the lowest matching k.
- stall, issue, fwd_sel1, fwd_sel2 and rf_busy are combinational from slot state and inputs. Each output has zero-cycle latency.
- issue = id_valid & ~stall & ~flush.
- flush has priority: when flush=1, stall=0 and issue=0, and a bubble is inserted. Already-issued slots are never killed.
- stall is 0 when id_valid=0.
- Same-cycle WB write of a register read in decode counts as a hazard. The RF has no internal write-through.
- Both operands may hit different slots. stall is the OR of both per-operand stall conditions.
- stall_cnt increments when stall=1 and saturates at all-ones.
- Reset (rst=0 at an edge): all slots v=0, stall_cnt=0. Immediately after reset: stall=0, rf_busy=0, fwd_sel1=fwd_sel2=0.
- Reset mid-operation discards all in-flight tracking.

Optional Feature:
- Macro: RF_FORWARD_EN.
- Defined:
  - stall only when an operand's youngest match is slot 0 with ld=1 (load-use); this costs 1 bubble.
  - Otherwise fwd_selN = youngest match index + 1, capped at 3 for slots ≥2, or 0 when there is no match.
- Undefined:
  - stall whenever any operand matches any slot.
  - fwd_sel1 and fwd_sel2 are tied to 0.
  - Load-to-use stalls for DEPTH cycles.

Test Plan:
- Reset: hold rst=0 two cycles with id_valid=1 -> stall=0, rf_busy=0, stall_cnt=0.
- ALU dependency: issue add x5 (we=1, wsel=0), next cycle addi x6,x5 (rs1=5 used) ->
  - FORWARD_EN: stall=0, fwd_sel1=1.
  - Without FORWARD_EN: stall=1 for 3 cycles, then issue=1.
- Load-use: issue lw x7 (wsel=1), then add x8,x7,x7 ->
  - FORWARD_EN: stall=1 for exactly 1 cycle, then fwd_sel1=fwd_sel2=2.
  - stall_cnt=1.
- x0 and unused operand: issue add x0, then add rs1=0; then lui rd=9 with rs2=9 and rs2_used=0 -> stall=0, rf_busy[0]=0.
- Flush during stall: lw x3 then dependent add with flush=1 in the same cycle -> stall=0, issue=0, slot[0] bubble, stall_cnt unchanged.
- Saturation: with CNT_W=4, force 20 consecutive stall cycles -> stall_cnt=15 and stays at 15.

Source files
------------

// File: rtl/rf_hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: decode instruction fields in, issue/stall/bypass controls out.
interface rf_hazard_scoreboard_if #(
    parameter int unsigned CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_rf_we;
    logic [1:0]       id_rf_wsel;
    logic             flush;
    logic             stall;
    logic             issue;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic [31:0]      rf_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rf_we,
               id_rf_wsel, flush,
        input  stall, issue, fwd_sel1, fwd_sel2, rf_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rf_we,
               id_rf_wsel, flush,
        output stall, issue, fwd_sel1, fwd_sel2, rf_busy, stall_cnt
    );
endinterface

// File: rtl/rf_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations over DEPTH slots (EX..WB).
// Define RF_FORWARD_EN to enable operand bypass selects and stall only on load-use.
module rf_hazard_scoreboard #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 32
) (
    input logic                  clk,
    input logic                  rst,
    rf_hazard_scoreboard_if.slave bus
);
    logic             v_q  [DEPTH];
    logic [4:0]       rd_q [DEPTH];
    logic             we_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;

    logic [DEPTH-1:0] writing;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;
    logic             chk1;
    logic             chk2;
    logic             stall1;
    logic             stall2;
    logic             stall;
    logic             issue;
    logic [31:0]      busy;

    assign chk1 = bus.id_rs1_used & (bus.id_rs1 != 5'd0);
    assign chk2 = bus.id_rs2_used & (bus.id_rs2 != 5'd0);

    always_comb begin
        writing = '0;
        hit1    = '0;
        hit2    = '0;
        busy    = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            writing[k] = v_q[k] & we_q[k] & (rd_q[k] != 5'd0);
            hit1[k]    = chk1 & writing[k] & (rd_q[k] == bus.id_rs1);
            hit2[k]    = chk2 & writing[k] & (rd_q[k] == bus.id_rs2);
            if (writing[k]) busy[rd_q[k]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

`ifdef RF_FORWARD_EN
    logic ld_q [DEPTH];
    logic [2:0] idx1;
    logic [2:0] idx2;

    function automatic logic [1:0] sel_of(input logic hit, input logic [2:0] idx);
        if (!hit)           return 2'd0;
        else if (idx >= 3'd2) return 2'd3;
        else                return idx[1:0] + 2'd1;
    endfunction

    // Scan oldest to youngest so the lowest matching slot wins.
    always_comb begin
        idx1 = '0;
        idx2 = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (hit1[k]) idx1 = 3'(k);
            if (hit2[k]) idx2 = 3'(k);
        end
    end

    assign stall1       = (|hit1) & (idx1 == 3'd0) & ld_q[0];
    assign stall2       = (|hit2) & (idx2 == 3'd0) & ld_q[0];
    assign bus.fwd_sel1 = sel_of(|hit1, idx1);
    assign bus.fwd_sel2 = sel_of(|hit2, idx2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < int'(DEPTH); k++) ld_q[k] <= 1'b0;
        end else begin
            ld_q[0] <= (bus.id_rf_wsel == 2'd1);
            for (int k = 1; k < int'(DEPTH); k++) ld_q[k] <= ld_q[k-1];
        end
    end
`else
    assign stall1       = |hit1;
    assign stall2       = |hit2;
    assign bus.fwd_sel1 = 2'd0;
    assign bus.fwd_sel2 = 2'd0;
`endif

    // A redirect kills the decode instruction, so it never waits on a hazard.
    assign stall = bus.id_valid & ~bus.flush & (stall1 | stall2);
    assign issue = bus.id_valid & ~stall & ~bus.flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                v_q[k]  <= 1'b0;
                rd_q[k] <= 5'd0;
                we_q[k] <= 1'b0;
            end
            cnt_q <= '0;
        end else begin
            v_q[0]  <= issue;
            rd_q[0] <= bus.id_rd;
            we_q[0] <= bus.id_rf_we;
            for (int k = 1; k < int'(DEPTH); k++) begin
                v_q[k]  <= v_q[k-1];
                rd_q[k] <= rd_q[k-1];
                we_q[k] <= we_q[k-1];
            end
            if (stall && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall     = stall;
    assign bus.issue     = issue;
    assign bus.rf_busy   = busy;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// Directed bench for rf_hazard_scoreboard (DEPTH=3, CNT_W=4); expectations follow RF_FORWARD_EN.
module tb_rf_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rf_hazard_scoreboard_if #(.CNT_W(4)) sb ();

    rf_hazard_scoreboard #(.DEPTH(3), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic we, input logic [1:0] wsel, input logic fl);
        sb.id_valid    = v;
        sb.id_rs1      = rs1;
        sb.id_rs1_used = u1;
        sb.id_rs2      = rs2;
        sb.id_rs2_used = u2;
        sb.id_rd       = rd;
        sb.id_rf_we    = we;
        sb.id_rf_wsel  = wsel;
        sb.flush       = fl;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'd0, 1'b0);
        step();
        step();
        #1;
        checks++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h want 0", sb.stall); end
        checks++; if (sb.rf_busy !== 32'h0) begin errors++; $display("FAIL rst_busy got %0h want 0", sb.rf_busy); end
        checks++; if (sb.stall_cnt !== 4'h0) begin errors++; $display("FAIL rst_cnt got %0h want 0", sb.stall_cnt); end
        checks++; if (sb.fwd_sel1 !== 2'd0 || sb.fwd_sel2 !== 2'd0) begin errors++; $display("FAIL rst_fwd got %0h/%0h want 0/0", sb.fwd_sel1, sb.fwd_sel2); end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_alu_dep();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 2'd0, 1'b0);
        #1;
        checks++; if (sb.issue !== 1'b1) begin errors++; $display("FAIL alu_first_issue got %0h want 1", sb.issue); end
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd0, 1'b0);
        #1;
        checks++; if (sb.rf_busy !== 32'h20) begin errors++; $display("FAIL alu_busy got %0h want 20", sb.rf_busy); end
`ifdef RF_FORWARD_EN
        checks++; if (sb.stall !== 1'b0 || sb.issue !== 1'b1) begin errors++; $display("FAIL alu_fwd_issue got stall %0h issue %0h want 0 1", sb.stall, sb.issue); end
        checks++; if (sb.fwd_sel1 !== 2'd1) begin errors++; $display("FAIL alu_fwd_sel1 got %0h want 1", sb.fwd_sel1); end
`else
        for (int i = 0; i < 3; i++) begin
            checks++; if (sb.stall !== 1'b1 || sb.issue !== 1'b0) begin errors++; $display("FAIL alu_stall%0d got stall %0h issue %0h want 1 0", i, sb.stall, sb.issue); end
            step();
        end
        checks++; if (sb.stall !== 1'b0 || sb.issue !== 1'b1) begin errors++; $display("FAIL alu_release got stall %0h issue %0h want 0 1", sb.stall, sb.issue); end
        checks++; if (sb.stall_cnt !== 4'd3) begin errors++; $display("FAIL alu_cnt got %0h want 3", sb.stall_cnt); end
`endif
        step();
        set_id(1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 2'd0, 1'b0);
        #1;
        checks++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL alu_invalid_stall got %0h want 0", sb.stall); end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 2'd1, 1'b0);
        step();
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 2'd0, 1'b0);
        #1;
`ifdef RF_FORWARD_EN
        checks++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0h want 1", sb.stall); end
        step();
        checks++; if (sb.stall !== 1'b0 || sb.issue !== 1'b1) begin errors++; $display("FAIL lu_release got stall %0h issue %0h want 0 1", sb.stall, sb.issue); end
        checks++; if (sb.fwd_sel1 !== 2'd2 || sb.fwd_sel2 !== 2'd2) begin errors++; $display("FAIL lu_fwd got %0h/%0h want 2/2", sb.fwd_sel1, sb.fwd_sel2); end
        checks++; if (sb.stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0h want 1", sb.stall_cnt); end
`else
        for (int i = 0; i < 3; i++) begin
            checks++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL lu_stall%0d got %0h want 1", i, sb.stall); end
            step();
        end
        checks++; if (sb.stall !== 1'b0 || sb.issue !== 1'b1) begin errors++; $display("FAIL lu_release got stall %0h issue %0h want 0 1", sb.stall, sb.issue); end
        checks++; if (sb.stall_cnt !== 4'd3) begin errors++; $display("FAIL lu_cnt got %0h want 3", sb.stall_cnt); end
`endif
        idle();
    endtask

    task automatic test_x0_unused();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 2'd0, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'd0, 1'b0);
        #1;
        checks++; if (sb.stall !== 1'b0 || sb.issue !== 1'b1) begin errors++; $display("FAIL x0_read got stall %0h issue %0h want 0 1", sb.stall, sb.issue); end
        checks++; if (sb.rf_busy !== 32'h0) begin errors++; $display("FAIL x0_busy got %0h want 0", sb.rf_busy); end
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 2'd3, 1'b0);
        #1;
        checks++; if (sb.stall !== 1'b0 || sb.issue !== 1'b1) begin errors++; $display("FAIL lui_issue got stall %0h issue %0h want 0 1", sb.stall, sb.issue); end
        step();
        set_id(1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd10, 1'b1, 2'd0, 1'b0);
        #1;
        checks++; if (sb.rf_busy !== 32'h200) begin errors++; $display("FAIL lui_busy got %0h want 200", sb.rf_busy); end
        checks++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL unused_stall got %0h want 0", sb.stall); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0);
        step();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'd0, 1'b1);
        #1;
        checks++; if (sb.stall !== 1'b0 || sb.issue !== 1'b0) begin errors++; $display("FAIL flush_ctl got stall %0h issue %0h want 0 0", sb.stall, sb.issue); end
        step();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0);
        #1;
        checks++; if (sb.rf_busy !== 32'h8) begin errors++; $display("FAIL flush_busy got %0h want 8", sb.rf_busy); end
        checks++; if (sb.stall_cnt !== 4'd0) begin errors++; $display("FAIL flush_cnt got %0h want 0", sb.stall_cnt); end
`ifdef RF_FORWARD_EN
        checks++; if (sb.stall !== 1'b0 || sb.fwd_sel1 !== 2'd2) begin errors++; $display("FAIL flush_after got stall %0h fwd1 %0h want 0 2", sb.stall, sb.fwd_sel1); end
`else
        checks++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL flush_after got %0h want 1", sb.stall); end
`endif
        idle();
    endtask

    task automatic test_two_operands();
        int n;
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd0, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 2'd0, 1'b0);
        step();
        set_id(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 2'd0, 1'b0);
        #1;
        checks++; if (sb.rf_busy !== 32'hC00) begin errors++; $display("FAIL two_busy got %0h want c00", sb.rf_busy); end
`ifdef RF_FORWARD_EN
        checks++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL two_stall got %0h want 0", sb.stall); end
        checks++; if (sb.fwd_sel1 !== 2'd2 || sb.fwd_sel2 !== 2'd1) begin errors++; $display("FAIL two_fwd got %0h/%0h want 2/1", sb.fwd_sel1, sb.fwd_sel2); end
`else
        checks++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL two_stall got %0h want 1", sb.stall); end
`endif
        n = 0;
        while (sb.issue !== 1'b1 && n < 10) begin
            step();
            n++;
        end
`ifdef RF_FORWARD_EN
        checks++; if (n !== 0) begin errors++; $display("FAIL two_wait got %0d want 0", n); end
`else
        checks++; if (n !== 3) begin errors++; $display("FAIL two_wait got %0d want 3", n); end
`endif
        step();
        idle();
        step();
        step();
        set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'd0, 1'b0);
        #1;
`ifdef RF_FORWARD_EN
        checks++; if (sb.stall !== 1'b0 || sb.fwd_sel1 !== 2'd3) begin errors++; $display("FAIL wb_fwd got stall %0h fwd1 %0h want 0 3", sb.stall, sb.fwd_sel1); end
`else
        checks++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL wb_stall got %0h want 1", sb.stall); end
`endif
        step();
        checks++; if (sb.stall !== 1'b0 || sb.issue !== 1'b1) begin errors++; $display("FAIL wb_retired got stall %0h issue %0h want 0 1", sb.stall, sb.issue); end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0);
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd0, 1'b0);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++; if (sb.rf_busy !== 32'h0) begin errors++; $display("FAIL mid_busy got %0h want 0", sb.rf_busy); end
        checks++; if (sb.stall !== 1'b0 || sb.stall_cnt !== 4'd0) begin errors++; $display("FAIL mid_state got stall %0h cnt %0h want 0 0", sb.stall, sb.stall_cnt); end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 2'd1, 1'b0);
        repeat (8) step();
`ifdef RF_FORWARD_EN
        checks++; if (sb.stall_cnt !== 4'd4) begin errors++; $display("FAIL sat_mid got %0h want 4", sb.stall_cnt); end
`else
        checks++; if (sb.stall_cnt !== 4'd6) begin errors++; $display("FAIL sat_mid got %0h want 6", sb.stall_cnt); end
`endif
        repeat (52) step();
        checks++; if (sb.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach got %0h want f", sb.stall_cnt); end
        repeat (10) step();
        checks++; if (sb.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0h want f", sb.stall_cnt); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_dep();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_two_operands();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
